fetch_pred_unit: RTL and testbench
==================================

FETCH_PRED_UNIT -- requirements
Module: fetch_pred_unit

Interface
REQ-001 SHALL have parameter WordSize, default 32: PC/address width in bits.
REQ-002 SHALL have parameter Entries, default 16: predictor table depth; power of two, 2 to 256.
REQ-003 SHALL have parameter ResetPC, default 0: fetch PC loaded on reset.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: reset; synchronous, active-high.
REQ-006 SHALL have port stall  input  1: hold fetch PC this cycle.
REQ-007 SHALL have port redirect  input  1: execute-stage flush; load redirect_pc.
REQ-008 SHALL have port redirect_pc  input  WordSize: corrected next PC from execute.
REQ-009 SHALL have port upd_valid  input  1: resolved conditional branch present this cycle.
REQ-010 SHALL have port upd_pc  input  WordSize: PC of resolved branch.
REQ-011 SHALL have port upd_target  input  WordSize: computed branch target.
REQ-012 SHALL have port upd_taken  input  1: actual branch outcome.
REQ-013 SHALL have port fetch_pc  output  WordSize: current fetch PC (registered).
REQ-014 SHALL have port pred_taken  output  1: prediction for fetch_pc.
REQ-015 SHALL have port pred_addr  output  WordSize: predicted target for fetch_pc.
REQ-016 SHALL have port pred_pc  output  WordSize: fall-through PC, fetch_pc+4.

Function
REQ-017 SHALL hold per table entry: valid bit, tag, WordSize-bit target, 2-bit saturating counter.
REQ-018 SHALL index with IW=log2(Entries): index = pc[IW+1:2], tag = pc[WordSize-1:IW+2]; pc[1:0] ignored.
REQ-019 SHALL compute pred_taken combinationally = entry valid AND tag match AND counter[1], from fetch_pc and current table state.
REQ-020 SHALL drive pred_addr = stored target on tag hit, else fetch_pc+4.
REQ-021 SHALL compute pred_pc = fetch_pc+4 modulo 2^WordSize; wrap from FFFFFFFC to 00000000.
REQ-022 SHALL select next fetch_pc, priority order: redirect -> redirect_pc; stall -> hold; pred_taken -> pred_addr; else pred_pc.
REQ-023 SHALL let redirect override stall in the same cycle.
REQ-024 SHALL on upd_valid with tag hit: increment counter if upd_taken (saturate at 3), else decrement (saturate at 0); replace target with upd_target when upd_taken.
REQ-025 SHALL on upd_valid with miss and upd_taken: allocate (overwrite) indexed entry: valid=1, new tag, target=upd_target, counter=2.
REQ-026 SHALL on upd_valid with miss and not upd_taken: leave table unchanged.
REQ-027 SHALL apply table updates at the clock edge; a same-cycle lookup of the updated index SHALL see pre-update contents (no bypass).
REQ-028 SHALL process updates regardless of stall or redirect.

Reset
REQ-029 SHALL on rst high at a clock edge: fetch_pc=ResetPC, all valid bits=0, all counters=1; targets/tags don't-care.
REQ-030 SHALL give rst priority over redirect, stall and upd_valid in the same cycle.
REQ-031 SHALL after reset drive pred_taken=0, pred_addr=pred_pc=ResetPC+4 until a taken branch is allocated.

Configuration
REQ-032 SHALL, when FETCH_PRED_STATS_EN is defined, add output stat_hits [15:0]: counts cycles with pred_taken=1, stall=0, redirect=0, saturating at FFFF, cleared by rst.
REQ-033 SHALL, when FETCH_PRED_STATS_EN is undefined, omit stat_hits and its counter entirely; all other behaviour identical.

Verification
REQ-034 SHALL test reset: rst for 2 cycles, ResetPC=0x100 -> fetch_pc=0x100, pred_taken=0, pred_pc=0x104; next cycle fetch_pc=0x104.
REQ-035 SHALL test allocation: upd_valid, upd_pc=0x108, upd_target=0x200, upd_taken=1 -> when fetch_pc reaches 0x108, pred_taken=1, pred_addr=0x200, next fetch_pc=0x200.
REQ-036 SHALL test hysteresis: from counter=2 at 0x108, one not-taken update -> pred_taken=0; second taken update -> pred_taken=1; three taken then one not-taken -> still 1.
REQ-037 SHALL test aliasing: Entries=16, entry at 0x108 allocated, taken update for 0x148 -> 0x108 now misses, 0x148 hits.
REQ-038 SHALL test priority: stall=1 and redirect=1, redirect_pc=0x300 -> fetch_pc=0x300 next cycle; stall alone -> fetch_pc unchanged.
REQ-039 SHALL test wrap and stats: fetch_pc=0xFFFFFFFC, no hit -> next 0x00000000; with FETCH_PRED_STATS_EN, 5 unstalled hit cycles -> stat_hits=5.

Source files
------------

// File: rtl/fetch_pred_unit_if.sv
// Bus interface for fetch_pred_unit.
// Carries the fetch control, redirect, and branch-resolution inputs, plus the
// prediction outputs.
// The optional hit counter (stat_hits) exists only when FETCH_PRED_STATS_EN is
// defined.
//
// Handshake: there is no valid/ready pair on this bus. Outputs are meaningful
// every cycle. The driver presents stall/redirect/upd_* for the current cycle.
// The unit consumes them at the next rising clock edge. upd_* fields are
// looked at only while upd_valid is high.
interface fetch_pred_unit_if #(
    parameter int WordSize = 32
);
    logic                stall;
    logic                redirect;
    logic [WordSize-1:0] redirect_pc;
    logic                upd_valid;
    logic [WordSize-1:0] upd_pc;
    logic [WordSize-1:0] upd_target;
    logic                upd_taken;
    logic [WordSize-1:0] fetch_pc;
    logic                pred_taken;
    logic [WordSize-1:0] pred_addr;
    logic [WordSize-1:0] pred_pc;
`ifdef FETCH_PRED_STATS_EN
    logic [15:0]         stat_hits;

    modport slave (
        input  stall, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output fetch_pc, pred_taken, pred_addr, pred_pc, stat_hits
    );

    modport master (
        output stall, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  fetch_pc, pred_taken, pred_addr, pred_pc, stat_hits
    );
`else
    modport slave (
        input  stall, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output fetch_pc, pred_taken, pred_addr, pred_pc
    );

    modport master (
        output stall, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  fetch_pc, pred_taken, pred_addr, pred_pc
    );
`endif
endinterface

// File: rtl/fetch_pred_unit.sv
// fetch_pred_unit: fetch PC register with a direct-mapped branch target
// predictor.
// Each entry holds a valid bit, a tag, a target, and a 2-bit saturating
// counter.
// Lookups use the registered fetch_pc. Updates arrive from execute and take
// effect at the clock edge. A lookup never sees an update from the same cycle.
// Optional feature: define FETCH_PRED_STATS_EN to add the 16-bit saturating
// stat_hits counter.
// Entries must be a power of two between 2 and 256.
module fetch_pred_unit #(
    parameter int                  WordSize = 32,
    parameter int                  Entries  = 16,
    parameter logic [WordSize-1:0] ResetPC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    fetch_pred_unit_if.slave bus
);
    localparam int IW = $clog2(Entries);
    localparam int TW = WordSize - IW - 2;
    localparam logic [WordSize-1:0] PcStep = WordSize'(4);

    // Predictor table and fetch PC state
    logic                r_valid  [Entries];
    logic [TW-1:0]       r_tag    [Entries];
    logic [WordSize-1:0] r_target [Entries];
    logic [1:0]          r_ctr    [Entries];
    logic [WordSize-1:0] r_fetch_pc;

    // Lookup side (fetch_pc)
    logic [IW-1:0]       w_f_idx;
    logic [TW-1:0]       w_f_tag;
    logic                w_f_hit;
    logic                w_pred_taken;
    logic [WordSize-1:0] w_pred_addr;
    logic [WordSize-1:0] w_pred_pc;
    logic [WordSize-1:0] w_next_pc;

    // Update side (upd_pc)
    logic [IW-1:0]       w_u_idx;
    logic [TW-1:0]       w_u_tag;
    logic                w_u_hit;
    logic [1:0]          w_ctr_next;

    // Byte-offset bits of instruction addresses are ignored by design
    logic                w_unused_lsbs;
    assign w_unused_lsbs = ^{r_fetch_pc[1:0], bus.upd_pc[1:0]};

    // Lookup: index and tag come from the registered fetch PC
    always_comb begin
        w_f_idx      = r_fetch_pc[IW+1:2];
        w_f_tag      = r_fetch_pc[WordSize-1:IW+2];
        w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        w_pred_pc    = r_fetch_pc + PcStep;
        w_pred_taken = w_f_hit && r_ctr[w_f_idx][1];
        w_pred_addr  = w_f_hit ? r_target[w_f_idx] : w_pred_pc;
    end

    // Next fetch PC: redirect beats stall, stall beats the prediction
    always_comb begin
        w_next_pc = w_pred_pc;
        if (bus.redirect) begin
            w_next_pc = bus.redirect_pc;
        end else if (bus.stall) begin
            w_next_pc = r_fetch_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_addr;
        end
    end

    // Update decode: hit detection and saturating counter step
    always_comb begin
        w_u_idx    = bus.upd_pc[IW+1:2];
        w_u_tag    = bus.upd_pc[WordSize-1:IW+2];
        w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
        w_ctr_next = r_ctr[w_u_idx];
        if (bus.upd_taken) begin
            if (r_ctr[w_u_idx] != 2'd3) begin
                w_ctr_next = r_ctr[w_u_idx] + 2'd1;
            end
        end else begin
            if (r_ctr[w_u_idx] != 2'd0) begin
                w_ctr_next = r_ctr[w_u_idx] - 2'd1;
            end
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= ResetPC;
        end else begin
            r_fetch_pc <= w_next_pc;
        end
    end

    // Valid bits and counters are reset to "empty, weakly not-taken"
    // A not-taken miss leaves the table untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'd1;
            end
        end else if (bus.upd_valid) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= w_ctr_next;
            end else if (bus.upd_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_ctr[w_u_idx]   <= 2'd2;
            end
        end
    end

    // Tag/target storage has no reset
    // A taken update always writes the target
    // On a hit the tag is rewritten with the same value
    always_ff @(posedge clk) begin
        if (!rst && bus.upd_valid && bus.upd_taken) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= bus.upd_target;
        end
    end

    assign bus.fetch_pc   = r_fetch_pc;
    assign bus.pred_taken = w_pred_taken;
    assign bus.pred_addr  = w_pred_addr;
    assign bus.pred_pc    = w_pred_pc;

`ifdef FETCH_PRED_STATS_EN
    logic [15:0] r_stat_hits;

    // Count cycles where a taken prediction actually steers fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits <= 16'd0;
        end else if (w_pred_taken && !bus.stall && !bus.redirect &&
                     (r_stat_hits != 16'hFFFF)) begin
            r_stat_hits <= r_stat_hits + 16'd1;
        end
    end

    assign bus.stat_hits = r_stat_hits;
`endif

endmodule

// File: tb/tb_fetch_pred_unit.sv
// Testbench for fetch_pred_unit.
// The driver issues one cycle of inputs per call. It pushes the expected
// outputs for that cycle into a queue. A monitor on the falling edge pops and
// compares those expectations.
module tb_fetch_pred_unit;
    localparam int W  = 32;
    localparam int EW = 3 * W + 1;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_RST  = 3'b100;
    localparam logic [2:0] C_STL  = 3'b010;
    localparam logic [2:0] C_RD   = 3'b001;
    localparam logic [1:0] U_NO   = 2'b00;
    localparam logic [1:0] U_T    = 2'b11;
    localparam logic [1:0] U_NT   = 2'b10;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [EW-1:0] exp_q[$];
`ifdef FETCH_PRED_STATS_EN
    logic [15:0]   stat_q[$];
`endif

    fetch_pred_unit_if #(.WordSize(W)) bus ();

    fetch_pred_unit #(
        .WordSize(W),
        .Entries (16),
        .ResetPC (32'h100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; expectation describes outputs during this cycle
    task automatic cyc(input logic [2:0] ctl, input logic [W-1:0] rpc,
                       input logic [1:0] up, input logic [W-1:0] upc,
                       input logic [W-1:0] utgt, input logic chk,
                       input logic [W-1:0] epc, input logic ept,
                       input logic [W-1:0] epa);
        {rst, bus.stall, bus.redirect} = ctl;
        bus.redirect_pc = rpc;
        {bus.upd_valid, bus.upd_taken} = up;
        bus.upd_pc = upc;
        bus.upd_target = utgt;
        if (chk) exp_q.push_back({epc, ept, epa, epc + 32'd4});
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fetch_pc",   bus.fetch_pc,            e[EW-1 -: W]);
            check("pred_taken", {31'b0, bus.pred_taken}, {31'b0, e[2*W]});
            check("pred_addr",  bus.pred_addr,           e[2*W-1 -: W]);
            check("pred_pc",    bus.pred_pc,             e[W-1:0]);
        end
`ifdef FETCH_PRED_STATS_EN
        if (stat_q.size() != 0) begin
            check("stat_hits", {16'b0, bus.stat_hits}, {16'b0, stat_q.pop_front()});
        end
`endif
    end

    // Directed stimulus
    initial begin
        // reset for two cycles
        cyc(C_RST,  0, U_NO, 0, 0, 1'b0, 0, 1'b0, 0);
        cyc(C_RST,  0, U_NO, 0, 0, 1'b1, 32'h100, 1'b0, 32'h104);
        cyc(C_NONE, 0, U_NO, 0, 0, 1'b1, 32'h100, 1'b0, 32'h104);
        // allocate 0x108 -> 0x200, then follow it
        cyc(C_NONE, 0, U_T, 32'h108, 32'h200, 1'b1, 32'h104, 1'b0, 32'h108);
        cyc(C_NONE, 0, U_NO, 0, 0,            1'b1, 32'h108, 1'b1, 32'h200);
        // hysteresis at 0x108, fetch held there by stall
        cyc(C_RD, 32'h108, U_NT, 32'h108, 0,  1'b1, 32'h200, 1'b0, 32'h204);
        cyc(C_STL, 0, U_T,  32'h108, 32'h200, 1'b1, 32'h108, 1'b0, 32'h200);
        cyc(C_STL, 0, U_T,  32'h108, 32'h200, 1'b1, 32'h108, 1'b1, 32'h200);
        cyc(C_STL, 0, U_T,  32'h108, 32'h240, 1'b1, 32'h108, 1'b1, 32'h200);
        cyc(C_STL, 0, U_NT, 32'h108, 32'h3F0, 1'b1, 32'h108, 1'b1, 32'h240);
        cyc(C_NONE, 0, U_NO, 0, 0,            1'b1, 32'h108, 1'b1, 32'h240);
        // aliasing: 0x148 shares index 2 with 0x108; update during redirect
        cyc(C_RD, 32'h108, U_T, 32'h148, 32'h500, 1'b1, 32'h240, 1'b0, 32'h244);
        cyc(C_RD, 32'h148, U_NO, 0, 0,            1'b1, 32'h108, 1'b0, 32'h10C);
        // same-cycle update of the looked-up index is not bypassed
        cyc(C_NONE, 0, U_NT, 32'h148, 0,          1'b1, 32'h148, 1'b1, 32'h500);
        // not-taken miss must not allocate
        cyc(C_RD, 32'h148, U_NT, 32'h188, 32'h777, 1'b1, 32'h500, 1'b0, 32'h504);
        // priority: redirect beats stall, then stall holds
        cyc(C_STL | C_RD, 32'h300, U_NO, 0, 0, 1'b1, 32'h148, 1'b0, 32'h500);
        cyc(C_STL, 0, U_NO, 0, 0,              1'b1, 32'h300, 1'b0, 32'h304);
        // reset beats redirect and update
        cyc(C_RST | C_RD, 32'h700, U_T, 32'h300, 32'h600, 1'b1, 32'h300, 1'b0, 32'h304);
        cyc(C_RD, 32'h148, U_NO, 0, 0,         1'b1, 32'h100, 1'b0, 32'h104);
        cyc(C_RD, 32'h300, U_NO, 0, 0,         1'b1, 32'h148, 1'b0, 32'h14C);
        cyc(C_RD, 32'hFFFF_FFFC, U_NO, 0, 0,   1'b1, 32'h300, 1'b0, 32'h304);
        // wrap
        cyc(C_NONE, 0, U_NO, 0, 0,             1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        // self-loop branch at 0x8 gives continuous hit cycles
        cyc(C_NONE, 0, U_T, 32'h8, 32'h8,      1'b1, 32'h0, 1'b0, 32'h4);
        cyc(C_NONE, 0, U_NO, 0, 0,             1'b1, 32'h4, 1'b0, 32'h8);
        for (int i = 0; i < 5; i++) begin
            cyc(C_NONE, 0, U_NO, 0, 0,         1'b1, 32'h8, 1'b1, 32'h8);
        end
`ifdef FETCH_PRED_STATS_EN
        stat_q.push_back(16'd5);
`endif
        cyc(C_STL, 0, U_NO, 0, 0,              1'b1, 32'h8, 1'b1, 32'h8);
        cyc(C_NONE, 0, U_NO, 0, 0,             1'b1, 32'h8, 1'b1, 32'h8);
        repeat (2) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
